// File: rtl/fir_pkg.sv
// fir_pkg: shared constants, beat type and helpers for the FIR stream blocks
// Contents: DATA_WIDTH default stream width, DEFAULT_LEN default frame length,
//           axis_beat_t {data, last}, clog2 for sizing pointers and counters.
package fir_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int DEFAULT_LEN = 64;
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
    } axis_beat_t;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/fir_sync_fifo.sv
// fir_sync_fifo: circular pointer/storage FIFO with look-ahead head, full and level
// Ports: clk_i, rst_ni    clock, asynchronous active-low reset
//        clr_i            synchronous flush of both pointers
//        wr_i, wr_data_i  push one entry (caller guarantees not full)
//        rd_i             pop the current head entry
//        head_o/head_vld_o  head entry as it stands after this cycle's pop
//        full_nxt_o       full flag as it stands after this cycle's push/pop
//        level_o          current occupancy
module fir_sync_fifo
    import fir_pkg::*;
#(
    parameter int W = DATA_WIDTH,
    parameter int D = 8,
    localparam int AW = clog2(D)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         wr_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         rd_i,
    output logic [W-1:0] head_o,
    output logic         head_vld_o,
    output logic         full_nxt_o,
    output logic [AW:0]  level_o
);
    logic [W-1:0] mem_q [D];
    logic [AW:0]  wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    assign wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, wr_i};
    assign rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, rd_i};
    assign full_nxt_o = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    // Uses the pre-push write pointer, so a word pushed into an empty FIFO
    // reaches the output register one edge after it is written.
    assign head_vld_o = wr_ptr_q != rd_ptr_d;
    assign head_o     = mem_q[rd_ptr_d[AW-1:0]];
    assign level_o    = wr_ptr_q - rd_ptr_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= clr_i ? '0 : wr_ptr_d;
            rd_ptr_q <= clr_i ? '0 : rd_ptr_d;
        end
    end
    always_ff @(posedge clk_i) begin
        if (wr_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
endmodule

// File: rtl/fir_axis_out_buf.sv
// fir_axis_out_buf: FIR output stream buffer with tlast regeneration and tlast checking
// Ports: axis_clk, axis_rst_n   clock, asynchronous active-low reset
//        clr                    synchronous flush of FIFO, counters and flags
//        cfg_len                samples per frame, 0 = unbounded
//        s_t*                   upstream stream from the FIR core (s_tlast is only checked)
//        m_t*                   downstream stream, m_tlast regenerated from cfg_len
//        level                  FIFO occupancy, including the word shown on m_*
//        done_pulse             one cycle after the final-sample handshake
//        err_tlast              sticky: s_tlast disagreed with the input count
//        level_max              high-water mark of level (only with OUT_BUF_LEVEL_MAX_EN)
module fir_axis_out_buf
    import fir_pkg::*;
#(
    parameter int pDATA_WIDTH = DATA_WIDTH,
    parameter int pDEPTH = 8,
    parameter int pLEN_WIDTH = 32,
    localparam int LW = clog2(pDEPTH) + 1
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   clr,
    input  logic [pLEN_WIDTH-1:0]  cfg_len,
    input  logic                   s_tvalid,
    input  logic [pDATA_WIDTH-1:0] s_tdata,
    input  logic                   s_tlast,
    output logic                   s_tready,
    output logic                   m_tvalid,
    output logic [pDATA_WIDTH-1:0] m_tdata,
    output logic                   m_tlast,
    input  logic                   m_tready,
    output logic [LW-1:0]          level,
    output logic                   done_pulse,
    output logic                   err_tlast
`ifdef OUT_BUF_LEVEL_MAX_EN
    ,
    output logic [LW-1:0]          level_max
`endif
);
    localparam logic [pLEN_WIDTH-1:0] ONE = 1;
    logic                   s_tready_q, m_tvalid_q, done_q, err_q;
    logic [pDATA_WIDTH-1:0] m_tdata_q, head;
    logic [pLEN_WIDTH-1:0]  in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    logic                   wr, rd, head_vld, full_nxt, len_on, in_last;
    assign wr       = s_tvalid && s_tready_q;
    assign rd       = m_tvalid_q && m_tready;
    assign len_on   = cfg_len != '0;
    assign in_last  = len_on && (in_cnt_q == cfg_len - ONE);
    assign m_tlast  = m_tvalid_q && len_on && (out_cnt_q == cfg_len - ONE);
    // Counters wrap to 0 after a frame's last beat and saturate when unbounded.
    assign in_cnt_d  = !wr ? in_cnt_q : in_last ? '0 : &in_cnt_q ? in_cnt_q : in_cnt_q + ONE;
    assign out_cnt_d = !rd ? out_cnt_q : m_tlast ? '0 : &out_cnt_q ? out_cnt_q : out_cnt_q + ONE;
    assign s_tready   = s_tready_q;
    assign m_tvalid   = m_tvalid_q;
    assign m_tdata    = m_tdata_q;
    assign done_pulse = done_q;
    assign err_tlast  = err_q;
    fir_sync_fifo #(.W(pDATA_WIDTH), .D(pDEPTH)) u_fifo (
        .clk_i      (axis_clk),
        .rst_ni     (axis_rst_n),
        .clr_i      (clr),
        .wr_i       (wr),
        .wr_data_i  (s_tdata),
        .rd_i       (rd),
        .head_o     (head),
        .head_vld_o (head_vld),
        .full_nxt_o (full_nxt),
        .level_o    (level)
    );
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            s_tready_q <= 1'b0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else if (clr) begin
            s_tready_q <= 1'b1;
            m_tvalid_q <= 1'b0;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            s_tready_q <= !full_nxt;
            m_tvalid_q <= head_vld;
            m_tdata_q  <= head_vld ? head : m_tdata_q;
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            done_q     <= rd && m_tlast;
            err_q      <= err_q || (wr && (s_tlast != in_last));
        end
    end
`ifdef OUT_BUF_LEVEL_MAX_EN
    logic [LW-1:0] level_max_q;
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) level_max_q <= '0;
        else level_max_q <= clr ? '0 : (level > level_max_q) ? level : level_max_q;
    end
    assign level_max = level_max_q;
`endif
endmodule

// File: tb/tb_fir_axis_out_buf.sv
// tb_fir_axis_out_buf: scoreboard bench for fir_axis_out_buf with directed frames
module tb_fir_axis_out_buf;
    import fir_pkg::*;
    logic        clk = 1'b0;
    logic        axis_rst_n, clr, s_tvalid, s_tlast, m_tready;
    logic [31:0] cfg_len, s_tdata;
    logic        s_tready, m_tvalid, m_tlast, done_pulse, err_tlast;
    logic [DATA_WIDTH-1:0] m_tdata;
    logic [3:0]  level;
`ifdef OUT_BUF_LEVEL_MAX_EN
    logic [3:0]  level_max;
`endif
    logic [32:0] q[$];
    logic [32:0] e;
    logic        exp_done = 1'b0;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    fir_axis_out_buf dut (
        .axis_clk   (clk),
        .axis_rst_n (axis_rst_n),
        .clr        (clr),
        .cfg_len    (cfg_len),
        .s_tvalid   (s_tvalid),
        .s_tdata    (s_tdata),
        .s_tlast    (s_tlast),
        .s_tready   (s_tready),
        .m_tvalid   (m_tvalid),
        .m_tdata    (m_tdata),
        .m_tlast    (m_tlast),
        .m_tready   (m_tready),
        .level      (level),
        .done_pulse (done_pulse),
        .err_tlast  (err_tlast)
`ifdef OUT_BUF_LEVEL_MAX_EN
        ,
        .level_max  (level_max)
`endif
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", n, a, x);
        end
    endtask

    // data d with upstream last tl; el is the hand-computed regenerated last
    task automatic send(input logic [31:0] d, input logic tl, input logic el);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = tl;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (s_tready) begin
                q.push_back({el, d});
                @(posedge clk);
                #1;
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        total++;
        bad++;
        $display("FAIL send_timeout got=stuck exp=accept data=%0h", d);
        s_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (n < 300 && (q.size() != 0 || m_tvalid)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            total++;
            bad++;
            $display("FAIL drain_timeout got=%0d left exp=0", q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    always @(negedge clk) begin
        if (done_pulse || exp_done) chk("done_pulse", 32'(done_pulse), 32'(exp_done));
        exp_done = 1'b0;
        if (m_tvalid && m_tready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out got=%0h exp=none", m_tdata);
            end else begin
                e = q.pop_front();
                chk("m_tdata", m_tdata, e[31:0]);
                chk("m_tlast", 32'(m_tlast), 32'(e[32]));
                exp_done = e[32];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        axis_rst_n = 1'b0; clr = 1'b0; cfg_len = 4; s_tvalid = 1'b0;
        s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_tready", 32'(s_tready), 0);
        chk("rst_m_tvalid", 32'(m_tvalid), 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_m_tlast", 32'(m_tlast), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_done", 32'(done_pulse), 0);
        chk("rst_err", 32'(err_tlast), 0);
        @(negedge clk) axis_rst_n = 1'b1;
        chk("s_tready_before_edge", 32'(s_tready), 0);
        @(posedge clk);
        #1;
        chk("s_tready_rise", 32'(s_tready), 1);
        // basic frame of 4
        m_tready = 1'b1;
        for (int i = 1; i <= 4; i++) send(32'(i), i == 4, i == 4);
        drain();
        chk("t1_err", 32'(err_tlast), 0);
        // back-pressure: fill 8, two more wait for space
        cfg_len = 10;
        m_tready = 1'b0;
        for (int i = 1; i <= 8; i++) send(32'h100 + 32'(i), 1'b0, 1'b0);
        chk("t2_s_tready_full", 32'(s_tready), 0);
        chk("t2_level_full", 32'(level), 8);
        chk("t2_m_tvalid", 32'(m_tvalid), 1);
        fork
            begin
                send(32'h109, 1'b0, 1'b0);
                send(32'h10a, 1'b1, 1'b1);
            end
            begin
                repeat (3) @(posedge clk);
                #1 m_tready = 1'b1;
            end
        join
        drain();
        chk("t2_err", 32'(err_tlast), 0);
        // read with blocked write at full, then 3 frames of 8 across pointer wrap
        cfg_len = 8;
        m_tready = 1'b0;
        for (int i = 0; i < 8; i++) send(32'h200 + 32'(i), i == 7, i == 7);
        m_tready = 1'b1; s_tvalid = 1'b1; s_tdata = 32'h208; s_tlast = 1'b0;
        @(negedge clk);
        chk("t3_s_tready_blocked", 32'(s_tready), 0);
        chk("t3_level_8", 32'(level), 8);
        @(posedge clk);
        #1;
        chk("t3_level_7", 32'(level), 7);
        chk("t3_s_tready_back", 32'(s_tready), 1);
        for (int i = 8; i < 24; i++) send(32'h200 + 32'(i), i % 8 == 7, i % 8 == 7);
        drain();
        chk("t3_err", 32'(err_tlast), 0);
        // early s_tlast on the 3rd word of a 5-word frame
        cfg_len = 5;
        for (int i = 1; i <= 5; i++) begin
            send(32'h300 + 32'(i), i == 3, i == 5);
            if (i == 2) chk("t4_err_before", 32'(err_tlast), 0);
            if (i == 3) chk("t4_err_set", 32'(err_tlast), 1);
        end
        drain();
        chk("t4_err_sticky", 32'(err_tlast), 1);
        pulse_clr();
        chk("t4_err_clr", 32'(err_tlast), 0);
        // unbounded frame length
        cfg_len = 0;
        for (int i = 0; i < 20; i++) send(32'h400 + 32'(i), 1'b0, 1'b0);
        drain();
        chk("t5_err", 32'(err_tlast), 0);
        // asynchronous reset with 5 words buffered
        pulse_clr();
        cfg_len = 8;
        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) send(32'h500 + 32'(i), 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("t6_level_5", 32'(level), 5);
`ifdef OUT_BUF_LEVEL_MAX_EN
        chk("t6_level_max_5", 32'(level_max), 5);
`endif
        axis_rst_n = 1'b0;
        #1;
        q.delete();
        chk("t6_rst_m_tvalid", 32'(m_tvalid), 0);
        chk("t6_rst_m_tdata", m_tdata, 0);
        chk("t6_rst_level", 32'(level), 0);
        chk("t6_rst_s_tready", 32'(s_tready), 0);
`ifdef OUT_BUF_LEVEL_MAX_EN
        chk("t6_rst_level_max", 32'(level_max), 0);
`endif
        @(negedge clk) axis_rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_rel_s_tready", 32'(s_tready), 1);
        chk("t6_rel_level", 32'(level), 0);
        // same again, flushed with clr
        for (int i = 0; i < 5; i++) send(32'h600 + 32'(i), 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("t6c_level_5", 32'(level), 5);
`ifdef OUT_BUF_LEVEL_MAX_EN
        chk("t6c_level_max_5", 32'(level_max), 5);
`endif
        pulse_clr();
        q.delete();
        chk("t6c_level", 32'(level), 0);
        chk("t6c_m_tvalid", 32'(m_tvalid), 0);
        chk("t6c_s_tready", 32'(s_tready), 1);
`ifdef OUT_BUF_LEVEL_MAX_EN
        chk("t6c_level_max", 32'(level_max), 0);
`endif
        // counters restart cleanly after the flush
        cfg_len = 2;
        m_tready = 1'b1;
        send(32'h701, 1'b0, 1'b0);
        send(32'h702, 1'b1, 1'b1);
        drain();
        chk("t6c_err", 32'(err_tlast), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fir_axis_out_buf.md
Name: fir_axis_out_buf

Overview:
- Output-side stream buffer placed directly downstream of the FIR core's AXI-Stream master port (sm_*), feeding the DMA / testbench stream sink.
- Absorbs output back-pressure in a small FIFO so the FIR MAC loop never stalls on sm_tready.
- Regenerates m_tlast from a programmed frame length. Checks the incoming tlast against that length and reports frame completion and tlast errors.

Parameters:
- pDATA_WIDTH, 32, stream data width.
- pDEPTH, 8, FIFO entries. Must be a power of 2, minimum 2.
- pLEN_WIDTH, 32, width of the frame-length configuration and output counter.

Ports:
- axis_clk  in  1  clock.
- axis_rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous flush of FIFO, counters and sticky flags.
- cfg_len  in  pLEN_WIDTH  samples per frame (data_length register value). 0 means unbounded.
- s_tvalid  in  1  upstream (FIR sm_tvalid).
- s_tdata  in  pDATA_WIDTH  upstream data.
- s_tlast  in  1  upstream last flag.
- s_tready  out  1  buffer can accept.
- m_tvalid  out  1  downstream valid.
- m_tdata  out  pDATA_WIDTH  downstream data.
- m_tlast  out  1  regenerated last.
- m_tready  in  1  downstream ready.
- level  out  clog2(pDEPTH)+1  current occupancy.
- done_pulse  out  1  one-cycle pulse on the final-sample handshake.
- err_tlast  out  1  sticky: s_tlast disagreed with the length count.

Behaviour:
- Reset (async, axis_rst_n low), all outputs are 0:
  - s_tready=0 during reset; it rises to 1 on the first clock edge after release.
  - m_tvalid=0, m_tdata=0, m_tlast=0, level=0, done_pulse=0, err_tlast=0.
  - wr_ptr, rd_ptr, in_cnt and out_cnt are cleared.
- FIFO storage:
  - Circular buffer of pDEPTH entries with pointers one bit wider than the address.
  - full = (MSBs differ, lower bits equal); empty = (pointers equal).
  - s_tready = registered !full_next, so a write is never accepted when full, even if a read occurs in the same cycle.
  - Write on s_tvalid&&s_tready. Read on m_tvalid&&m_tready.
- Output side:
  - Registered output stage. m_tvalid/m_tdata update on the clock edge.
  - Latency: a word written at edge N appears on m_* after edge N+1 (two edges, input to output) when the FIFO is empty.
  - m_tdata and m_tlast hold stable while m_tvalid=1 and m_tready=0.
  - Continuous throughput of 1 word/cycle once primed with m_tready=1.
- Simultaneous read and write: both proceed and level is unchanged. At level==pDEPTH the write is blocked because s_tready=0.
- Pointer wrap-around is natural modulo 2*pDEPTH. No special case.
- tlast regeneration:
  - out_cnt increments on each output handshake.
  - m_tlast = (cfg_len!=0) && (out_cnt of the presented word == cfg_len-1).
  - On the handshake with m_tlast=1: out_cnt returns to 0 and done_pulse=1 for exactly the following cycle.
  - cfg_len==0: m_tlast is never asserted and out_cnt saturates at all-ones.
- tlast check:
  - in_cnt counts input handshakes using the same rule as out_cnt.
  - If s_tlast=1 on an input handshake where in_cnt!=cfg_len-1, or s_tlast=0 where in_cnt==cfg_len-1 (cfg_len!=0), err_tlast sets and stays set until clr or reset.
  - The stored s_tlast bit is not forwarded.
- cfg_len is sampled live. Changing it mid-frame is illegal; no behaviour is guaranteed for that case.
- clr has priority over all other events in its cycle:
  - Empties the FIFO and zeroes counters, m_tvalid, err_tlast and done_pulse.
  - s_tready=1 the next cycle.
- Reset mid-operation discards all contents immediately (asynchronous).

Optional Feature:
- Macro OUT_BUF_LEVEL_MAX_EN.
- Defined:
  - Adds output port level_max (same width as level), a high-water mark of level.
  - Updated each cycle to max(level_max, level).
  - Cleared by reset and clr.
- Undefined: the port, register and comparator are absent. All other behaviour is identical.

Decomposition:
- Shared package fir_pkg:
  - DATA_WIDTH constant.
  - Default frame-length constant.
  - clog2 function.
  - Typedef for axis beat {data, last}.
- One natural sub-module: fir_sync_fifo, the plain pointer/storage FIFO with full/empty/level.
- fir_axis_out_buf wraps fir_sync_fifo with the output register, counters, tlast logic and flags.

Test Plan:
1. Basic frame: cfg_len=4, m_tready=1, push 1,2,3,4 back-to-back.
   - m_* outputs 1,2,3,4 with m_tlast only on 4.
   - done_pulse one cycle after the 4 handshake; err_tlast=0.
2. Full back-pressure: pDEPTH=8, m_tready=0, push 10 words.
   - s_tready drops after the 8th accept and level=8.
   - Raise m_tready: all 10 drain in order with no loss or duplication.
3. Simultaneous read/write at level=8 with m_tready=1 and s_tvalid=1.
   - Write blocked that cycle. Next cycle level=7 and s_tready=1.
   - Pointers wrap correctly over 3 full frames of 8 (cfg_len=8).
4. tlast mismatch: cfg_len=5, drive s_tlast=1 on the 3rd word.
   - err_tlast=1 from the next cycle and stays set.
   - m_tlast still asserted only on the 5th output.
   - clr returns err_tlast to 0.
5. Unbounded length: cfg_len=0, push 20 words.
   - m_tlast never asserted and done_pulse never pulses.
6. Reset and clr mid-frame: assert axis_rst_n low with level=5.
   - Outputs go to 0 immediately; after release, s_tready=1 and level=0.
   - Repeat with clr: same result one cycle later.
   - With OUT_BUF_LEVEL_MAX_EN defined, level_max=5 before and 0 after.
